alu_cmd_driver: RTL and testbench

- Initiator side of the 8-bit ALU interface (operands a/b, 3-bit op, result y).
- Accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Drives each command onto the ALU operand/op lines, waits a fixed settle time, samples y, and returns the result over a valid/ready response stream.
- Replaces free-running op stepping with an ordered, back-pressured command path.

---
 rtl/alu_cmd_driver.sv | 206 ++++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: initiator side of a combinational WIDTH-bit ALU.
// Commands (op, a, b) arrive on a valid/ready stream into a small FIFO. Each
// command is driven onto alu_a/alu_b/alu_op. After ALU_LAT edges, alu_y is
// sampled and returned on a valid/ready response stream. A divide by zero is
// answered directly with res_y = all ones and res_err = 1, and is never
// driven to the ALU.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_op/cmd_a/cmd_b                command payload
//   alu_a/alu_b/alu_op                operands driven to the ALU, held between commands
//   alu_y                             ALU result
//   res_valid/res_ready               response handshake
//   res_y/res_op/res_err              response payload
//   busy                              work queued or in flight
module alu_cmd_driver #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic [2:0]       res_op,
  output logic             res_err,
  output logic             busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = 4;
  localparam logic [2:0]  OP_DIV = 3'b011;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [LAT_W-1:0] lat_cnt_q;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             cmd_ready_q;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  cmd_t             cmd_in;
  cmd_t             head;

  assign cmd_in     = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  // The ready seen by the producer is registered, so a pop while full
  // only reopens the input on the following cycle.
  assign push       = cmd_valid && cmd_ready_q;
  assign pop        = (state_q == IDLE) && !fifo_empty;

  // Occupancy after this edge.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and registered ready. The pointers wrap naturally
  // because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE pops, EXEC waits for the ALU to settle, RESP holds the
  // result until it is taken.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_op_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_y_q;
  logic [2:0]       res_op_q;
  logic             res_err_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            busy_q <= 1'b1;
            if ((head.op == OP_DIV) && (head.b == '0)) begin
              // Rejected without touching the ALU lines.
              res_y_q     <= '1;
              res_op_q    <= OP_DIV;
              res_err_q   <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              alu_a_q   <= head.a;
              alu_b_q   <= head.b;
              alu_op_q  <= head.op;
              lat_cnt_q <= LAT_W'(ALU_LAT - 1);
              state_q   <= EXEC;
            end
          end else begin
            busy_q <= (count_d != '0);
          end
        end

        EXEC: begin
          busy_q <= 1'b1;
          if (lat_cnt_q != '0) begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end else begin
            res_y_q     <= alu_y;
            res_op_q    <= alu_op_q;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end

        RESP: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
            busy_q      <= (count_d != '0);
          end else begin
            busy_q <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= (count_d != '0);
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver. dut0 runs with ALU_LAT=1 and dut1 with
// ALU_LAT=3. Each instance has a behavioural ALU on its alu_* lines.
// Inputs are driven and outputs sampled on the falling edge.
module tb_alu_cmd_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0 (ALU_LAT = 1)
  logic       c0_valid, c0_ready, r0_valid, r0_ready, r0_err, busy0;
  logic [2:0] c0_op, a0_op, r0_op;
  logic [7:0] c0_a, c0_b, a0_a, a0_b, a0_y, r0_y;
  // dut1 (ALU_LAT = 3)
  logic       c1_valid, c1_ready, r1_valid, r1_ready, r1_err, busy1;
  logic [2:0] c1_op, a1_op, r1_op;
  logic [7:0] c1_a, c1_b, a1_a, a1_b, a1_y, r1_y;

  alu_cmd_driver #(.WIDTH(8), .ALU_LAT(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_op(c0_op), .cmd_a(c0_a), .cmd_b(c0_b),
    .alu_a(a0_a), .alu_b(a0_b), .alu_op(a0_op), .alu_y(a0_y),
    .res_valid(r0_valid), .res_ready(r0_ready), .res_y(r0_y), .res_op(r0_op),
    .res_err(r0_err), .busy(busy0)
  );

  alu_cmd_driver #(.WIDTH(8), .ALU_LAT(3), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_op(c1_op), .cmd_a(c1_a), .cmd_b(c1_b),
    .alu_a(a1_a), .alu_b(a1_b), .alu_op(a1_op), .alu_y(a1_y),
    .res_valid(r1_valid), .res_ready(r1_ready), .res_y(r1_y), .res_op(r1_op),
    .res_err(r1_err), .busy(busy1)
  );

  // Behavioural 8-bit ALU with results truncated to 8 bits.
  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return p[7:0];
      3'd3:    return (b == 8'd0) ? 8'hFF : a / b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return ~a;
      default: return a ^ b;
    endcase
  endfunction

  assign a0_y = alu_model(a0_op, a0_a, a0_b);
  assign a1_y = alu_model(a1_op, a1_a, a1_b);

  // Response capture: {op, err, y} of every completed handshake.
  logic [11:0] q0[$];
  logic [11:0] q1[$];
  always @(posedge clk) begin
    if (r0_valid && r0_ready) q0.push_back({r0_op, r0_err, r0_y});
    if (r1_valid && r1_ready) q1.push_back({r1_op, r1_err, r1_y});
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command and return on the falling edge after it is accepted.
  task automatic push(input bit sel, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int guard;
    guard = 0;
    if (!sel) begin c0_valid = 1'b1; c0_op = op; c0_a = a; c0_b = b; end
    else      begin c1_valid = 1'b1; c1_op = op; c1_a = a; c1_b = b; end
    while (!(sel ? c1_ready : c0_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("push_timeout", 32'(sel ? c1_ready : c0_ready), 32'd1);
    @(negedge clk);
    if (!sel) c0_valid = 1'b0;
    else      c1_valid = 1'b0;
  endtask

  task automatic wait_q(input bit sel, input int n, input string tag);
    int guard;
    guard = 0;
    while (((sel ? q1.size() : q0.size()) < n) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(sel ? q1.size() : q0.size()), 32'(n));
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    int guard;
    guard = 0;
    while ((sel ? busy1 : busy0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(sel ? busy1 : busy0), 32'd0);
  endtask

  logic [7:0] y1 [8] = '{8'd10, 8'd4, 8'd21, 8'd2, 8'd3, 8'd7, 8'd248, 8'd4};
  logic [2:0] op3 [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd7};
  logic [7:0] a3 [6]  = '{8'd20, 8'd20, 8'd20, 8'd12, 8'd12, 8'd12};
  logic [7:0] b3 [6]  = '{8'd5, 8'd5, 8'd5, 8'd10, 8'd10, 8'd10};
  logic [7:0] y3 [6]  = '{8'd25, 8'd15, 8'd100, 8'd8, 8'd14, 8'd6};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  extra;
    int  guard;
    bit  acc;
    c0_valid = 1'b0; c0_op = '0; c0_a = '0; c0_b = '0; r0_ready = 1'b1;
    c1_valid = 1'b0; c1_op = '0; c1_a = '0; c1_b = '0; r1_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_alu", 32'({a0_a, a0_b, a0_op}), 32'd0);
    check("rst_res", 32'({r0_valid, r0_err, r0_op, r0_y, busy0}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(c0_ready), 32'd1);

    // 1: a=7, b=3 through every opcode, back to back
    for (int i = 0; i < 8; i++) push(1'b0, 3'(i), 8'd7, 8'd3);
    wait_q(1'b0, 8, "t1_count");
    for (int i = 0; i < 8; i++) check("t1_res", 32'(q0[i]), 32'({3'(i), 1'b0, y1[i]}));
    check("t1_idle", 32'(busy0), 32'd0);

    // 2: divide by zero answered one cycle after the pop, ALU lines untouched
    q0.delete();
    push(1'b0, 3'd3, 8'd9, 8'd0);
    check("t2_pre", 32'(r0_valid), 32'd0);
    @(negedge clk);
    check("t2_div_res", 32'({r0_valid, r0_err, r0_op, r0_y}), 32'({1'b1, 1'b1, 3'd3, 8'hFF}));
    check("t2_alu_hold", 32'({a0_a, a0_b, a0_op}), 32'({8'd7, 8'd3, 3'd7}));
    @(negedge clk);
    check("t2_div_taken", 32'(q0.size()), 32'd1);
    push(1'b0, 3'd0, 8'd1, 8'd1);
    check("t2_add_lat0", 32'(r0_valid), 32'd0);
    @(negedge clk);
    check("t2_add_lat1", 32'(r0_valid), 32'd0);
    @(negedge clk);
    check("t2_add_res", 32'({r0_valid, r0_err, r0_op, r0_y}), 32'({1'b1, 1'b0, 3'd0, 8'd2}));
    wait_idle(1'b0, "t2_idle");

    // 3: back-pressure fills FSM plus FIFO, then drains in order
    q0.delete();
    r0_ready = 1'b0;
    k = 0;
    c0_valid = 1'b1;
    for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
      c0_op = op3[k]; c0_a = a3[k]; c0_b = b3[k];
      acc = c0_ready;
      @(negedge clk);
      if (acc) k++;
    end
    check("t3_accepted", 32'(k), 32'd5);
    c0_op = op3[5]; c0_a = a3[5]; c0_b = b3[5];
    extra = 0;
    repeat (4) begin
      acc = c0_ready;
      @(negedge clk);
      if (acc) extra++;
    end
    check("t3_no_extra", 32'(extra), 32'd0);
    check("t3_full", 32'(c0_ready), 32'd0);
    r0_ready = 1'b1;
    check("t3_valid_held", 32'(r0_valid), 32'd1);
    @(negedge clk);
    check("t3_ready_after_hs", 32'(c0_ready), 32'd0);
    @(negedge clk);
    check("t3_ready_after_pop", 32'(c0_ready), 32'd1);
    @(negedge clk);
    c0_valid = 1'b0;
    wait_q(1'b0, 6, "t3_count");
    for (int i = 0; i < 6; i++) check("t3_order", 32'(q0[i]), 32'({op3[i], 1'b0, y3[i]}));
    wait_idle(1'b0, "t3_idle");

    // 4: pending result held for 10 cycles, next command stays queued
    q0.delete();
    r0_ready = 1'b0;
    push(1'b0, 3'd2, 8'd9, 8'd9);
    push(1'b0, 3'd1, 8'd9, 8'd4);
    guard = 0;
    while (!r0_valid && guard < 50) begin @(negedge clk); guard++; end
    check("t4_valid", 32'(r0_valid), 32'd1);
    repeat (10) begin
      check("t4_hold", 32'({r0_valid, r0_err, r0_op, r0_y}), 32'({1'b1, 1'b0, 3'd2, 8'd81}));
      check("t4_alu_hold", 32'({a0_a, a0_b, a0_op}), 32'({8'd9, 8'd9, 3'd2}));
      @(negedge clk);
    end
    check("t4_no_hs", 32'(q0.size()), 32'd0);
    r0_ready = 1'b1;
    @(negedge clk);
    check("t4_one_hs", 32'(q0.size()), 32'd1);
    check("t4_valid_drop", 32'(r0_valid), 32'd0);
    wait_q(1'b0, 2, "t4_count");
    check("t4_first", 32'(q0[0]), 32'({3'd2, 1'b0, 8'd81}));
    check("t4_second", 32'(q0[1]), 32'({3'd1, 1'b0, 8'd5}));
    wait_idle(1'b0, "t4_idle");

    // 5: ALU_LAT = 3, 200 + 100 wraps to 44
    push(1'b1, 3'd0, 8'd200, 8'd100);
    @(negedge clk);
    check("t5_alu_drive", 32'({a1_a, a1_b, a1_op}), 32'({8'd200, 8'd100, 3'd0}));
    for (int i = 0; i < 3; i++) begin
      check("t5_wait", 32'(r1_valid), 32'd0);
      @(negedge clk);
    end
    check("t5_res", 32'({r1_valid, r1_err, r1_op, r1_y}), 32'({1'b1, 1'b0, 3'd0, 8'd44}));
    @(negedge clk);
    check("t5_taken", 32'(q1.size()), 32'd1);

    // 6: async reset in EXEC with two queued commands discards everything
    q1.delete();
    push(1'b1, 3'd0, 8'd1, 8'd1);
    push(1'b1, 3'd1, 8'd5, 8'd2);
    push(1'b1, 3'd4, 8'd6, 8'd3);
    check("t6_busy_pre", 32'(busy1), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_alu", 32'({a1_a, a1_b, a1_op}), 32'd0);
    check("t6_rst_res", 32'({r1_valid, r1_err, r1_op, r1_y, busy1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_result", 32'(q1.size()), 32'd0);
    check("t6_idle", 32'(busy1), 32'd0);
    push(1'b1, 3'd0, 8'd2, 8'd3);
    wait_q(1'b1, 1, "t6_count");
    check("t6_new_res", 32'(q1[0]), 32'({3'd0, 1'b0, 8'd5}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
